logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single-bit two-input gate cells.
- Applies one of eight bitwise logic ops to WIDTH-bit operands.
- Output is a one-entry registered stage with valid/ready handshake, plus parity and zero flags.
- Keeps a running XOR checksum and a transaction counter, so it can sit in a streaming datapath or feed a self-checking bench.

---
 rtl/logic_unit_pipe.sv | 115 +++++++++++
 tb/tb_logic_unit_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise logic unit with a one-entry
// valid/ready output stage, result flags, XOR checksum and counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par,
  output logic             y_zero,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             par_q, par_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res;
  logic             accept;

  always_comb begin
    res = '0;
    unique case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_NOT:  res = ~a;
      OP_BUF:  res = a;
      default: res = '0;
    endcase
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flags come from the new result so they stay aligned with y.
  always_comb begin
    vld_d  = vld_q;
    y_d    = y_q;
    par_d  = par_q;
    zero_d = zero_q;
    if (accept) begin
      vld_d  = 1'b1;
      y_d    = res;
      par_d  = ~^res;
      zero_d = (res == '0);
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Clear takes effect before the same-cycle transaction is folded in.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (acc_clr) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (accept) begin
      acc_d = acc_d ^ res;
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      y_q    <= '0;
      par_q  <= 1'b0;
      zero_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      y_q    <= y_d;
      par_q  <= par_d;
      zero_q <= zero_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign y         = y_q;
  assign y_par     = par_q;
  assign y_zero    = zero_q;
  assign acc       = acc_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_par, y_zero;
  logic       acc_clr;
  logic [7:0] acc;
  logic [7:0] cnt;

  logic       in_ready2, out_valid2, y_par2, y_zero2;
  logic [7:0] y2, acc2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_par(y_par), .y_zero(y_zero),
    .acc_clr(acc_clr), .acc(acc), .cnt(cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .y_par(y_par2), .y_zero(y_zero2),
    .acc_clr(acc_clr), .acc(acc2), .cnt(cnt2)
  );

  function automatic logic [7:0] ref_op(
    input int o, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    case (o)
      0: r = x & z;
      1: r = x | z;
      2: r = x ^ z;
      3: r = ~(x ^ z);
      4: r = ~(x & z);
      5: r = ~(x | z);
      6: r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    acc_clr = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    acc_clr = 1'b0;
    a = '0; b = '0; op = '0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready_during got %b exp 1", in_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, y, acc, cnt, in_ready, y_par, y_zero}
        !== {1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_state got v=%b y=%h acc=%h cnt=%0d rdy=%b p=%b z=%b exp 0 00 00 0 1 0 0",
               out_valid, y, acc, cnt, in_ready, y_par, y_zero);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; op = 3'd3; a = 8'hA5; b = 8'h0F;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, y, y_par, y_zero, acc, cnt}
        !== {1'b1, 8'h55, 1'b1, 1'b0, 8'h55, 8'd1}) begin
      errors++;
      $display("FAIL single_xnor got v=%b y=%h p=%b z=%b acc=%h cnt=%0d exp 1 55 1 0 55 1",
               out_valid, y, y_par, y_zero, acc, cnt);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h05, 8'hAF, 8'hAA, 8'h55,
                8'hFA, 8'h50, 8'h5A, 8'hA5};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 3'(i); a = 8'hA5; b = 8'h0F;
      step();
      checks++;
      if ({out_valid, y, y_zero} !== {1'b1, exp_tab[i], 1'b0}) begin
        errors++;
        $display("FAIL op%0d got v=%b y=%h z=%b exp 1 %h 0",
                 i, out_valid, y, y_zero, exp_tab[i]);
      end
    end
    op = 3'd0; a = 8'hF0; b = 8'h0F;
    step();
    in_valid = 1'b0;
    checks++;
    if ({y, y_zero, y_par} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_flag got y=%h z=%b p=%b exp 00 1 1",
               y, y_zero, y_par);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h0F;
    out_ready = 1'b0;
    step();
    op = 3'd1; a = 8'hF0; b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, y} !== {1'b0, 1'b1, 8'h0F}) begin
        errors++;
        $display("FAIL stall%0d got rdy=%b v=%b y=%h exp 0 1 0f",
                 i, in_ready, out_valid, y);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, y, acc, cnt}
        !== {1'b1, 8'hF0, 8'hFF, 8'd2}) begin
      errors++;
      $display("FAIL b2b got v=%b y=%h acc=%h cnt=%0d exp 1 f0 ff 2",
               out_valid, y, acc, cnt);
    end
  endtask

  task automatic test_clear_collision();
    in_valid = 1'b1; op = 3'd0; a = 8'h3C; b = 8'hFF;
    out_ready = 1'b1; acc_clr = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({acc, cnt, y} !== {8'h3C, 8'd1, 8'h3C}) begin
      errors++;
      $display("FAIL clr_accept got acc=%h cnt=%0d y=%h exp 3c 1 3c",
               acc, cnt, y);
    end
    step();
    acc_clr = 1'b0;
    checks++;
    if ({acc, cnt, y} !== {8'h00, 8'd0, 8'h3C}) begin
      errors++;
      $display("FAIL clr_alone got acc=%h cnt=%0d y=%h exp 00 0 3c",
               acc, cnt, y);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; op = 3'd7; a = 8'h5A; b = 8'h00;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, y} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL pre_rst got v=%b y=%h exp 1 5a", out_valid, y);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, y, acc, cnt, in_ready}
        !== {1'b0, 8'h00, 8'h00, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst got v=%b y=%h acc=%h cnt=%0d rdy=%b exp 0 00 00 0 1",
               out_valid, y, acc, cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; op = 3'd6; a = 8'h0F;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, y, cnt} !== {1'b1, 8'hF0, 8'd1}) begin
      errors++;
      $display("FAIL first_after_rst got v=%b y=%h cnt=%0d exp 1 f0 1",
               out_valid, y, cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] xa;
    int         k4;
    do_reset();
    xa = '0;
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd7; b = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      a = 8'(k);
      xa = xa ^ 8'(k);
      step();
      k4 = k % 4;
      checks++;
      if ({cnt2, y2, acc2, out_valid2, in_ready2, y_zero2, y_par2}
          !== {2'(k4), 8'(k), xa, 1'b1, 1'b1, 1'b0,
               1'($countones(k) % 2 == 0)}) begin
        errors++;
        $display("FAIL wrap%0d got cnt=%0d y=%h acc=%h exp cnt=%0d y=%h acc=%h",
                 k, cnt2, y2, acc2, k4, 8'(k), xa);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic       mv, mpar, mzero;
    logic [7:0] my, macc, r;
    int         mcnt;
    logic       acpt;
    do_reset();
    mv = 0; my = 0; mpar = 0; mzero = 0; macc = 0; mcnt = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      acc_clr   = 1'($urandom_range(0, 15) == 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== (!mv || out_ready)) begin
        errors++;
        $display("FAIL rnd_ready%0d got %b exp %b",
                 i, in_ready, (!mv || out_ready));
      end
      acpt = in_valid && (!mv || out_ready);
      r = ref_op(int'(op), a, b);
      if (acc_clr) begin
        macc = acpt ? r : 8'h00;
        mcnt = acpt ? 1 : 0;
      end else if (acpt) begin
        macc = macc ^ r;
        mcnt = (mcnt + 1) % 256;
      end
      if (acpt) begin
        mv = 1; my = r;
        mpar = ($countones(r) % 2 == 0);
        mzero = (r == 8'h00);
      end else if (mv && out_ready) begin
        mv = 0;
      end
      step();
      checks++;
      if ({out_valid, y, y_par, y_zero, acc, cnt}
          !== {mv, my, mpar, mzero, macc, 8'(mcnt)}) begin
        errors++;
        $display("FAIL rnd%0d got v=%b y=%h p=%b z=%b acc=%h cnt=%0d exp v=%b y=%h p=%b z=%b acc=%h cnt=%0d",
                 i, out_valid, y, y_par, y_zero, acc, cnt,
                 mv, my, mpar, mzero, macc, mcnt);
      end
    end
    in_valid = 1'b0;
    acc_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_all_ops();
    test_backpressure();
    test_clear_collision();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
